// File: rtl/imem_line_fetch.sv
// imem_line_fetch: instruction-side bridge that assembles BUS_WID-wide lines
// from MEM_WID-wide beats on a req/gnt/rvalid memory bus.
// Optional feature macro: IMEM_LBUF_EN (single-entry line buffer).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no fill in flight; accepts a new or pending request
// S_ADDR | mem_req/mem_addr driven for beat k, waiting for mem_gnt
// S_DATA | beat k granted, waiting for mem_rvalid
// (completion is taken on the last-beat edge: imem_resp is registered
//  there and the state returns to S_IDLE on that same edge)
module imem_line_fetch #(
   parameter int XLEN    = 32,
   parameter int BUS_WID = 64,
   parameter int MEM_WID = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               imem_req,
   input  logic [XLEN-1:0]    imem_addr,
   output logic [BUS_WID-1:0] imem_rdata,
   output logic               imem_resp,
   output logic               mem_req,
   output logic [XLEN-1:0]    mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [MEM_WID-1:0] mem_rdata
);

   localparam int BEATS      = BUS_WID / MEM_WID;
   localparam int BEAT_BYTES = MEM_WID / 8;
   localparam int OFF_W      = $clog2(BUS_WID / 8);
   localparam int K_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [K_W-1:0]  LAST_K    = K_W'(BEATS - 1);
   localparam logic [XLEN-1:0] LINE_MASK = ~((XLEN'(1) << OFF_W) - XLEN'(1));

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t             state;
   logic [K_W-1:0]     k;
   logic [BUS_WID-1:0] fill;
   logic [BUS_WID-1:0] fill_nxt;
   logic               pend_vld;
   logic [XLEN-1:0]    pend_line;
   logic [XLEN-1:0]    req_line;
   logic               lbuf_hit;
   logic [BUS_WID-1:0] hit_data;

`ifdef IMEM_LBUF_EN
   logic               lbuf_vld;
   logic [XLEN-1:0]    lbuf_tag;
   logic [BUS_WID-1:0] lbuf_data;
   logic [XLEN-1:0]    line_base;

   assign lbuf_hit = lbuf_vld && (lbuf_tag == req_line);
   assign hit_data = lbuf_data;
`else
   assign lbuf_hit = 1'b0;
   assign hit_data = '0;
`endif

   // line selected in IDLE: a live request is newer than anything pending
   always_comb begin
      req_line = (imem_req ? imem_addr : pend_line) & LINE_MASK;
   end

   // fill register with the incoming beat merged in; used for the last beat
   always_comb begin
      fill_nxt = fill;
      fill_nxt[int'(k)*MEM_WID +: MEM_WID] = mem_rdata;
   end

   // sequencing FSM with registered bus and core outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         imem_resp  <= 1'b0;
         imem_rdata <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         pend_vld   <= 1'b0;
         pend_line  <= '0;
         k          <= '0;
         fill       <= '0;
`ifdef IMEM_LBUF_EN
         lbuf_vld   <= 1'b0;
         lbuf_tag   <= '0;
         lbuf_data  <= '0;
         line_base  <= '0;
`endif
      end else begin
         imem_resp <= 1'b0;
         // the running fill cannot be aborted, so later requests queue here
         if (imem_req && (state != S_IDLE)) begin
            pend_vld  <= 1'b1;
            pend_line <= imem_addr & LINE_MASK;
         end
         case (state)
            S_IDLE: begin
               if (imem_req || pend_vld) begin
                  pend_vld <= 1'b0;
                  if (lbuf_hit) begin
                     imem_rdata <= hit_data;
                     imem_resp  <= 1'b1;
                  end else begin
`ifdef IMEM_LBUF_EN
                     line_base <= req_line;
`endif
                     mem_addr <= req_line;
                     mem_req  <= 1'b1;
                     k        <= '0;
                     state    <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (mem_rvalid) begin
                  fill <= fill_nxt;
                  if (k == LAST_K) begin
`ifdef IMEM_LBUF_EN
                     lbuf_vld  <= 1'b1;
                     lbuf_tag  <= line_base;
                     lbuf_data <= fill_nxt;
`endif
                     // a newer request makes this line stale: answer nothing
                     if (!(pend_vld || imem_req)) begin
                        imem_rdata <= fill_nxt;
                        imem_resp  <= 1'b1;
                     end
                     state <= S_IDLE;
                  end else begin
                     k        <= k + K_W'(1);
                     mem_addr <= mem_addr + XLEN'(BEAT_BYTES);
                     mem_req  <= 1'b1;
                     state    <= S_ADDR;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_line_fetch.sv
// Testbench for imem_line_fetch (BUS_WID=64, MEM_WID=32, XLEN=32).
module tb_imem_line_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [63:0] imem_rdata;
   logic        imem_resp;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [31:0] seed;

   // memory responder knobs and state
   int  gnt_lat = 0;
   int  rv_lat = 0;
   bit  rand_lat = 0;
   bit  stray_en = 0;
   bit  keep_rv = 0;
   bit  rv_pending = 0;
   int  rv_cnt = 0;
   logic [31:0] rv_addr;
   bit  req_seen = 0;
   int  gwait = 0;
   int  last_rv_cyc = 0;
   logic [31:0] grant_log[$];

   imem_line_fetch #(.XLEN(32), .BUS_WID(64), .MEM_WID(32)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [63:0] exp_line(input logic [31:0] a);
      logic [31:0] base;
      logic [63:0] l;
      base = a & ~32'h7;
      for (int b = 0; b < 2; b++) l[b*32 +: 32] = mem_word(base + 32'(b*4));
      return l;
   endfunction

   // memory bus model: one outstanding beat, programmable gnt/rvalid delays
   initial begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (rst) req_seen = 0;
         if (rst && !keep_rv) begin
            rv_pending = 0;
         end else begin
            if (rv_pending) begin
               if (rv_cnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata = mem_word(rv_addr);
                  rv_pending = 0;
                  last_rv_cyc = cyc;
               end else rv_cnt--;
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = $urandom;
            end
            if (mem_req === 1'b1 && !rst) begin
               if (!req_seen) begin
                  req_seen = 1;
                  gwait = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
               end
               if (gwait == 0) begin
                  mem_gnt = 1'b1;
                  req_seen = 0;
                  grant_log.push_back(mem_addr);
                  rv_pending = 1;
                  rv_cnt = rand_lat ? int'($urandom_range(0, 3)) : rv_lat;
                  rv_addr = mem_addr;
               end else gwait--;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      imem_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_resp(input int limit, output bit got);
      got = 0;
      for (int i = 0; i < limit; i++) begin
         if (imem_resp === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (imem_resp !== 1'b0) begin miscompares++; $display("FAIL reset_resp got %b want 0", imem_resp); end
      vectors++;
      if (imem_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", imem_rdata); end
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      vectors++;
      if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
   endtask

   task automatic test_miss_zero_wait();
      logic exp_req;
      logic [31:0] exp_a;
      gnt_lat = 0; rv_lat = 0;
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h104;
      @(negedge clk);
      imem_req = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         exp_req = (c == 1 || c == 3);
         vectors++;
         if (mem_req !== exp_req) begin miscompares++; $display("FAIL miss_mem_req c=%0d got %b want %b", c, mem_req, exp_req); end
         if (exp_req) begin
            exp_a = (c == 1) ? 32'h100 : 32'h104;
            vectors++;
            if (mem_addr !== exp_a) begin miscompares++; $display("FAIL miss_mem_addr c=%0d got %h want %h", c, mem_addr, exp_a); end
         end
         vectors++;
         if (imem_resp !== (c == 5)) begin miscompares++; $display("FAIL miss_resp c=%0d got %b want %b", c, imem_resp, c == 5); end
         if (c == 5) begin
            vectors++;
            if (imem_rdata !== exp_line(32'h100)) begin miscompares++; $display("FAIL miss_rdata got %h want %h", imem_rdata, exp_line(32'h100)); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wait_states();
      int beat, hold, resp_cyc;
      logic prev_req;
      bit done;
      gnt_lat = 3; rv_lat = 2;
      beat = 0; hold = 0; prev_req = 1'b0; done = 0; resp_cyc = 0;
      @(negedge clk);
      imem_req = 1'b1; imem_addr = 32'h246;
      @(negedge clk);
      imem_req = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         if (mem_req === 1'b1) begin
            hold++;
            vectors++;
            if (mem_addr !== 32'h240 + 32'(beat*4)) begin miscompares++; $display("FAIL wait_addr beat=%0d got %h want %h", beat, mem_addr, 32'h240 + 32'(beat*4)); end
         end else if (prev_req === 1'b1) begin
            vectors++;
            if (hold != 4) begin miscompares++; $display("FAIL wait_hold beat=%0d got %0d want 4", beat, hold); end
            beat++; hold = 0;
         end
         if (imem_resp === 1'b1) begin
            done = 1;
            resp_cyc = cyc;
            vectors++;
            if (resp_cyc != last_rv_cyc + 1) begin miscompares++; $display("FAIL wait_resp_cycle got %0d want %0d", resp_cyc, last_rv_cyc + 1); end
            vectors++;
            if (imem_rdata !== exp_line(32'h240)) begin miscompares++; $display("FAIL wait_rdata got %h want %h", imem_rdata, exp_line(32'h240)); end
         end
         prev_req = mem_req;
         @(negedge clk);
      end
      vectors++;
      if (!done || beat != 2) begin miscompares++; $display("FAIL wait_complete done=%0d beats=%0d want 1 and 2", done, beat); end
      gnt_lat = 0; rv_lat = 0;
   endtask

   task automatic test_supersede();
      int nresp;
      gnt_lat = 1; rv_lat = 1;
      nresp = 0;
      grant_log.delete();
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h2100;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h2200;
      @(negedge clk); imem_req = 1'b0;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h2304;
      @(negedge clk); imem_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (imem_resp === 1'b1) begin
            nresp++;
            vectors++;
            if (imem_rdata !== exp_line(32'h2300)) begin miscompares++; $display("FAIL supersede_rdata got %h want %h", imem_rdata, exp_line(32'h2300)); end
         end
         @(negedge clk);
      end
      vectors++;
      if (nresp != 1) begin miscompares++; $display("FAIL supersede_resp_count got %0d want 1", nresp); end
      vectors++;
      if (grant_log.size() != 4) begin
         miscompares++; $display("FAIL supersede_grants got %0d beats want 4", grant_log.size());
      end else if (grant_log[0] !== 32'h2100 || grant_log[1] !== 32'h2104 ||
                   grant_log[2] !== 32'h2300 || grant_log[3] !== 32'h2304) begin
         miscompares++;
         $display("FAIL supersede_grants got %h %h %h %h want 2100 2104 2300 2304",
                  grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
      end
      gnt_lat = 0; rv_lat = 0;
   endtask

   task automatic test_line_buffer();
      bit got;
      gnt_lat = 0; rv_lat = 0;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h500;
      @(negedge clk); imem_req = 1'b0;
      wait_resp(30, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL lbuf_first_fill got no resp want resp"); end
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h504;
      @(negedge clk); imem_req = 1'b0;
`ifdef IMEM_LBUF_EN
      for (int c = 1; c <= 6; c++) begin
         vectors++;
         if (imem_resp !== (c == 1)) begin miscompares++; $display("FAIL lbuf_hit_resp c=%0d got %b want %b", c, imem_resp, c == 1); end
         vectors++;
         if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lbuf_hit_mem_req c=%0d got %b want 0", c, mem_req); end
         if (c == 1) begin
            vectors++;
            if (imem_rdata !== exp_line(32'h500)) begin miscompares++; $display("FAIL lbuf_hit_rdata got %h want %h", imem_rdata, exp_line(32'h500)); end
         end
         @(negedge clk);
      end
`else
      for (int c = 1; c <= 6; c++) begin
         vectors++;
         if (imem_resp !== (c == 5)) begin miscompares++; $display("FAIL nolbuf_resp c=%0d got %b want %b", c, imem_resp, c == 5); end
         vectors++;
         if (mem_req !== (c == 1 || c == 3)) begin miscompares++; $display("FAIL nolbuf_mem_req c=%0d got %b want %b", c, mem_req, (c == 1 || c == 3)); end
         if (c == 5) begin
            vectors++;
            if (imem_rdata !== exp_line(32'h500)) begin miscompares++; $display("FAIL nolbuf_rdata got %h want %h", imem_rdata, exp_line(32'h500)); end
         end
         @(negedge clk);
      end
`endif
   endtask

   task automatic test_back_to_back();
      bit got;
      gnt_lat = 0; rv_lat = 0;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h700;
      @(negedge clk); imem_req = 1'b0;
      wait_resp(30, got);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL b2b_first got no resp want resp"); end
      imem_req = 1'b1; imem_addr = 32'h803;
      @(negedge clk); imem_req = 1'b0;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin miscompares++; $display("FAIL b2b_mem_req got %b/%h want 1/00000800", mem_req, mem_addr); end
      wait_resp(30, got);
      vectors++;
      if (!got || imem_rdata !== exp_line(32'h800)) begin miscompares++; $display("FAIL b2b_rdata got %h (resp %0d) want %h", imem_rdata, got, exp_line(32'h800)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fill();
      bit got;
      int t0;
      gnt_lat = 0; rv_lat = 4; keep_rv = 1;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'h900;
      @(negedge clk); imem_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_data mem_req got %b want 0", mem_req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (imem_resp !== 1'b0 || imem_rdata !== 64'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL rstmid_outputs got resp=%b rdata=%h req=%b addr=%h want all 0", imem_resp, imem_rdata, mem_req, mem_addr);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         vectors++;
         if (imem_resp !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_rvalid i=%0d got resp=%b req=%b want 0 0", i, imem_resp, mem_req); end
      end
      keep_rv = 0; rv_lat = 0;
      @(negedge clk); imem_req = 1'b1; imem_addr = 32'hA00; t0 = cyc;
      @(negedge clk); imem_req = 1'b0;
      wait_resp(30, got);
      vectors++;
      if (!got || cyc != t0 + 5 || imem_rdata !== exp_line(32'hA00)) begin
         miscompares++;
         $display("FAIL rstmid_refetch got resp=%0d lat=%0d rdata=%h want 1 5 %h", got, cyc - t0, imem_rdata, exp_line(32'hA00));
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] newest;
      bit outstanding;
      outstanding = 0; newest = '0;
      rand_lat = 1; stray_en = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (imem_resp === 1'b1) begin
            vectors++;
            if (!outstanding || imem_rdata !== exp_line(newest)) begin
               miscompares++;
               $display("FAIL rand_resp i=%0d got %h (outstanding %0d) want %h", i, imem_rdata, outstanding, exp_line(newest));
            end
            outstanding = 0;
         end
         if (i < 400 && $urandom_range(0, 3) == 0) begin
            imem_req = 1'b1;
            imem_addr = ($urandom_range(0, 1) ? 32'hFFFF_FFE0 : 32'h0000_1000) + 32'($urandom_range(0, 31));
            newest = imem_addr;
            outstanding = 1;
         end else imem_req = 1'b0;
      end
      vectors++;
      if (outstanding) begin miscompares++; $display("FAIL rand_drain got unanswered request %h want none", newest); end
      rand_lat = 0; stray_en = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      seed = $urandom;
      rst = 1'b1;
      imem_req = 1'b0;
      imem_addr = '0;
      test_reset();
      test_miss_zero_wait();
      test_wait_states();
      test_supersede();
      test_line_buffer();
      test_back_to_back();
      test_reset_mid_fill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
